// File: rtl/cpu_ctrl_seq_pkg.sv
// cpu_ctrl_pkg: opcodes, step encoding and one-hot helper for the control unit
package cpu_ctrl_pkg;
  localparam int MAX_REGS = 16;
  localparam logic [2:0] OPC_MV   = 3'b000;
  localparam logic [2:0] OPC_MVI  = 3'b001;
  localparam logic [2:0] OPC_ADD  = 3'b010;
  localparam logic [2:0] OPC_SUB  = 3'b011;
  localparam logic [2:0] OPC_MVNZ = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;
  typedef enum logic [2:0] {T0, T1, T2, T3, HALT} step_t;
  function automatic logic [MAX_REGS-1:0] onehot(input logic [3:0] idx, input int n);
    return (int'(idx) < n) ? MAX_REGS'(1) << idx : '0;
  endfunction
  function automatic logic opc_legal(input logic [2:0] o);
    return o inside {OPC_MV, OPC_MVI, OPC_ADD, OPC_SUB, OPC_MVNZ, OPC_HALT};
  endfunction
endpackage

// File: rtl/cpu_ctrl_seq_onehot_dec.sv
// ctrl_onehot_dec: register index plus enable to one-hot write-enable vector
module ctrl_onehot_dec
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] vec
);
  assign vec = en ? NUM_REGS'(onehot(4'(idx), NUM_REGS)) : '0;
endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multicycle control unit owning the IR and the T0..T3 step counter
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int OPC_W = 3,
  parameter int DATA_W = 16,
  localparam int REG_IDX_W = $clog2(NUM_REGS),
  localparam int IR_W = OPC_W + 2 * REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic [DATA_W-1:0]    din,
  input  logic                 g_zero,
  output logic                 ir_in,
  output logic [NUM_REGS-1:0]  r_in,
  output logic                 r_out_en,
  output logic [REG_IDX_W-1:0] r_out_sel,
  output logic                 din_out,
  output logic                 g_out,
  output logic                 a_in,
  output logic                 g_in,
  output logic                 alu_sub,
  output logic                 done,
  output logic                 busy,
  output logic                 illegal,
  output logic                 halted
);
  localparam logic [REG_IDX_W:0] NREG = NUM_REGS[REG_IDX_W:0];
  step_t state, state_nx;
  logic [IR_W-1:0] ir;
  logic [OPC_W-1:0] opc;
  logic [REG_IDX_W-1:0] rx, ry;
  logic wr_en, bad, unused_din;
  assign unused_din = ^din[DATA_W-1:IR_W];
  assign opc = ir[IR_W-1 -: OPC_W];
  assign rx = ir[2*REG_IDX_W-1:REG_IDX_W];
  assign ry = ir[REG_IDX_W-1:0];
  assign bad = !opc_legal(opc) || {1'b0, rx} >= NREG || {1'b0, ry} >= NREG;
  assign busy = resetn && state inside {T1, T2, T3};
  assign halted = resetn && state == HALT;
  // step register and instruction latch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= T0;
      ir <= '0;
    end else begin
      state <= state_nx;
      if (ir_in) ir <= din[IR_W-1:0];
    end
  end
  // next step and control decode; everything held low while in reset
  always_comb begin
    state_nx = state;
    ir_in = 1'b0;
    wr_en = 1'b0;
    r_out_en = 1'b0;
    r_out_sel = '0;
    din_out = 1'b0;
    g_out = 1'b0;
    a_in = 1'b0;
    g_in = 1'b0;
    alu_sub = 1'b0;
    done = 1'b0;
    illegal = 1'b0;
    if (resetn) begin
      case (state)
        T0: begin
          ir_in = run;
          state_nx = run ? T1 : T0;
        end
        T1: begin
          state_nx = T0;
          if (bad) begin
            done = 1'b1;
            illegal = 1'b1;
          end else begin
            case (opc)
              OPC_MV: begin
                r_out_en = 1'b1;
                r_out_sel = ry;
                wr_en = 1'b1;
                done = 1'b1;
              end
              OPC_MVI: begin
                din_out = 1'b1;
                wr_en = 1'b1;
                done = 1'b1;
              end
              OPC_ADD, OPC_SUB: begin
                r_out_en = 1'b1;
                r_out_sel = rx;
                a_in = 1'b1;
                state_nx = T2;
              end
              OPC_MVNZ: begin
                r_out_en = !g_zero;
                r_out_sel = g_zero ? '0 : ry;
                wr_en = !g_zero;
                done = 1'b1;
              end
              default: begin
                done = 1'b1;
                state_nx = HALT;
              end
            endcase
          end
        end
        T2: begin
          r_out_en = 1'b1;
          r_out_sel = ry;
          g_in = 1'b1;
          alu_sub = opc == OPC_SUB;
          state_nx = T3;
        end
        T3: begin
          g_out = 1'b1;
          wr_en = 1'b1;
          done = 1'b1;
          state_nx = T0;
        end
        default: state_nx = HALT;
      endcase
    end
  end
  ctrl_onehot_dec #(.NUM_REGS(NUM_REGS)) u_dec (
    .idx(rx),
    .en (wr_en),
    .vec(r_in)
  );
endmodule
